line_buffer_arbiter: RTL and testbench

Shares one single-port 512x15 line-buffer RAM between two requesters.
- Write side: PPU pixel writer, 256 pixels per scanline into one of two banks.
- Read side: the VGA scan driver, which presents its next-cycle pixel address every clock and displays each source pixel for two VGA clocks (horizontal doubling).
- Reads have strict priority and fixed 1-cycle latency. Writes are buffered in a small FIFO and drained into idle RAM slots.

---
 rtl/linebuf_pkg.sv | 24 ++
 rtl/linebuf_wr_fifo.sv | 70 +++++++
 rtl/line_buffer_arbiter.sv | 168 ++++++++++++++++
 tb/tb_line_buffer_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/linebuf_pkg.sv
// Shared definitions for the line-buffer arbiter.
//   LB_ADDR_W : line-buffer RAM address width ({bank, column})
//   LB_COLS   : source pixels per scanline
//   LB_DATA_W : pixel width (5:5:5 BGR)
//   lb_wr_t   : one queued PPU pixel write {bank, x, data}
//   lb_addr() : RAM address targeted by a queued write
package linebuf_pkg;

  localparam int unsigned LB_ADDR_W = 9;
  localparam int unsigned LB_COLS   = 256;
  localparam int unsigned LB_X_W    = $clog2(LB_COLS);
  localparam int unsigned LB_DATA_W = 15;

  typedef struct packed {
    logic                 bank;
    logic [LB_X_W-1:0]    x;
    logic [LB_DATA_W-1:0] data;
  } lb_wr_t;

  function automatic logic [LB_ADDR_W-1:0] lb_addr(input lb_wr_t e);
    return {e.bank, e.x};
  endfunction

endpackage

// File: rtl/linebuf_wr_fifo.sv
// Synchronous FIFO of pending PPU writes.
// Optional feature macro: LINEBUF_FWD_EN (exposes storage and head pointer for forwarding).
// Ports:
//   clk, reset  : clock, synchronous active-high reset (flushes contents)
//   push/wdata  : enqueue when push && !full
//   pop         : dequeue head when pop && !empty
//   head        : oldest entry
//   full/empty  : status flags
//   count       : number of valid entries
//   entries     : raw storage (LINEBUF_FWD_EN only)
//   head_ptr    : storage index of the oldest entry (LINEBUF_FWD_EN only)
module linebuf_wr_fifo
  import linebuf_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH),
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  lb_wr_t                        wdata,
  input  logic                          pop,
  output lb_wr_t                        head,
  output logic                          full,
  output logic                          empty,
  output logic [CNT_W-1:0]              count
`ifdef LINEBUF_FWD_EN
  ,
  output lb_wr_t [FIFO_DEPTH-1:0]       entries,
  output logic [PTR_W-1:0]              head_ptr
`endif
);

  lb_wr_t [FIFO_DEPTH-1:0] mem_q;
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]        count_q;
  logic                    do_push, do_pop;

  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

`ifdef LINEBUF_FWD_EN
  assign entries  = mem_q;
  assign head_ptr = rd_ptr_q;
`endif

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage is not reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/line_buffer_arbiter.sv
// Shares one single-port 512xDATA_W line-buffer RAM between the VGA scan reader
// (strict priority, fixed 1-cycle latency) and the PPU pixel writer (queued in a
// small FIFO and drained into idle slots).
// Optional feature macro: LINEBUF_FWD_EN -- reads hit queued writes to the same
// address (newest wins) instead of returning stale RAM data.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   wr_req/wr_bank/wr_x/wr_data, wr_ready : PPU write handshake
//   rd_en, rd_addr      : VGA next-pixel address {bank, column, phase}
//   rd_data             : pixel shown in the current VGA cycle
//   ram_addr/ram_we/ram_wdata, ram_q : single-port sync RAM (read-first)
module line_buffer_arbiter
  import linebuf_pkg::*;
#(
  parameter int unsigned DATA_W     = LB_DATA_W,  // must equal LB_DATA_W
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_req,
  input  logic                 wr_bank,
  input  logic [7:0]           wr_x,
  input  logic [DATA_W-1:0]    wr_data,
  output logic                 wr_ready,
  input  logic                 rd_en,
  input  logic [9:0]           rd_addr,
  output logic [DATA_W-1:0]    rd_data,
  output logic [LB_ADDR_W-1:0] ram_addr,
  output logic                 ram_we,
  output logic [DATA_W-1:0]    ram_wdata,
  input  logic [DATA_W-1:0]    ram_q
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [LB_ADDR_W-1:0] rd_src;
  logic [LB_ADDR_W-1:0] tag_q;
  logic                 tag_valid_q;
  logic                 rd_valid_q;
  logic [DATA_W-1:0]    rd_hold_q;
  logic                 rd_need;

  lb_wr_t               fifo_in, fifo_head;
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]     fifo_count;

  // Phase bit is dropped: both doubled VGA cycles map to one source pixel.
  assign rd_src  = rd_addr[9:1];
  assign rd_need = !reset && rd_en && (!tag_valid_q || (rd_src != tag_q));

  assign wr_ready     = !reset && !fifo_full;
  assign fifo_push    = wr_req && wr_ready;
  assign fifo_pop     = !reset && !rd_need && !fifo_empty;
  assign fifo_in.bank = wr_bank;
  assign fifo_in.x    = wr_x;
  assign fifo_in.data = wr_data;

`ifdef LINEBUF_FWD_EN
  lb_wr_t [FIFO_DEPTH-1:0] fifo_entries;
  logic [PTR_W-1:0]        fifo_head_ptr;
  logic                    fwd_hit, fwd_hit_q;
  logic [DATA_W-1:0]       fwd_data, fwd_data_q;
`else
  logic unused_fifo_count;
  assign unused_fifo_count = ^fifo_count;
`endif

  linebuf_wr_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .wdata    (fifo_in),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
`ifdef LINEBUF_FWD_EN
    ,
    .entries  (fifo_entries),
    .head_ptr (fifo_head_ptr)
`endif
  );

  // RAM slot: read beats queued write beats idle. A read and a write never
  // share a slot, so same-address collisions cannot happen at the port.
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (rd_need) begin
      ram_addr = rd_src;
    end else if (fifo_pop) begin
      ram_addr  = lb_addr(fifo_head);
      ram_we    = 1'b1;
      ram_wdata = fifo_head.data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q       <= '0;
      tag_valid_q <= 1'b0;
    end else if (!rd_en) begin
      // Forget the tag during blanking so the first active address refetches.
      tag_valid_q <= 1'b0;
    end else if (rd_need) begin
      tag_q       <= rd_src;
      tag_valid_q <= 1'b1;
    end
  end

`ifdef LINEBUF_FWD_EN
  // Scan oldest to newest; later matches overwrite, so the newest entry wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      idx = fifo_head_ptr + PTR_W'(i);
      if ((CNT_W'(i) < fifo_count) && (lb_addr(fifo_entries[idx]) == rd_src)) begin
        fwd_hit  = 1'b1;
        fwd_data = fifo_entries[idx].data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_hit_q  <= rd_need && fwd_hit;
      fwd_data_q <= fwd_data;
    end
  end
`endif

  // ram_q is valid the cycle after a read slot; otherwise hold the last pixel
  // so it is shown on both doubled VGA cycles.
  always_comb begin
    rd_data = rd_hold_q;
    if (reset) begin
      rd_data = '0;
    end else if (rd_valid_q) begin
`ifdef LINEBUF_FWD_EN
      rd_data = fwd_hit_q ? fwd_data_q : ram_q;
`else
      rd_data = ram_q;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_hold_q  <= '0;
    end else begin
      rd_valid_q <= rd_need;
      rd_hold_q  <= rd_data;
    end
  end

endmodule

// File: tb/tb_line_buffer_arbiter.sv
module tb_line_buffer_arbiter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_req, wr_bank;
  logic [7:0]  wr_x;
  logic [14:0] wr_data;
  logic        wr_ready;
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic [14:0] rd_data;
  logic [8:0]  ram_addr;
  logic        ram_we;
  logic [14:0] ram_wdata;
  logic [14:0] ram_q;

  always #5 clk = ~clk;

  line_buffer_arbiter #(
    .DATA_W     (15),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_req    (wr_req),
    .wr_bank   (wr_bank),
    .wr_x      (wr_x),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_q     (ram_q)
  );

  // External single-port RAM, synchronous read-first.
  logic [14:0] ram_mem [512];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_q <= ram_mem[ram_addr];
  end

  // Reference model: what the line buffer should contain, the queue of
  // accepted-but-unwritten pixels, and which source pixel is on screen.
  typedef struct {
    logic [8:0]  a;
    logic [14:0] d;
  } pend_t;
  pend_t       mq[$];
  logic [14:0] mmem [512];
  bit          m_fetched;
  logic [8:0]  m_last;
  logic [14:0] m_shown;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, check outputs mid-cycle, advance the model.
  task automatic step(input bit rst, input bit ren, input logic [9:0] raddr,
                      input bit wreq, input bit wbank, input logic [7:0] wx,
                      input logic [14:0] wd);
    bit          exp_ready, fetch;
    logic [8:0]  src;
    logic [14:0] val;
    reset = rst; rd_en = ren; rd_addr = raddr;
    wr_req = wreq; wr_bank = wbank; wr_x = wx; wr_data = wd;
    @(negedge clk);
    if (rst) begin
      check_val("rst_wr_ready", 32'(wr_ready), 0);
      check_val("rst_ram_we", 32'(ram_we), 0);
      check_val("rst_ram_addr", 32'(ram_addr), 0);
      check_val("rst_ram_wdata", 32'(ram_wdata), 0);
      mq.delete();
      m_fetched = 0;
      m_shown   = '0;
    end else begin
      exp_ready = (mq.size() < DEPTH);
      check_val("wr_ready", 32'(wr_ready), 32'(exp_ready));
      check_val("rd_data", 32'(rd_data), 32'(m_shown));
      src   = raddr[9:1];
      fetch = ren && !(m_fetched && src == m_last);
      if (fetch) begin
        check_val("read_we", 32'(ram_we), 0);
        check_val("read_addr", 32'(ram_addr), 32'(src));
        val = mmem[src];
`ifdef LINEBUF_FWD_EN
        foreach (mq[i]) if (mq[i].a == src) val = mq[i].d;
`endif
        m_shown   = val;
        m_fetched = 1;
        m_last    = src;
      end else if (mq.size() > 0) begin
        check_val("write_we", 32'(ram_we), 1);
        check_val("write_addr", 32'(ram_addr), 32'(mq[0].a));
        check_val("write_data", 32'(ram_wdata), 32'(mq[0].d));
        mmem[mq[0].a] = mq[0].d;
        void'(mq.pop_front());
      end else begin
        check_val("idle_we", 32'(ram_we), 0);
      end
      if (!ren) m_fetched = 0;
      if (wreq && exp_ready) mq.push_back('{a: {wbank, wx}, d: wd});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rd_only(input bit ren, input logic [9:0] raddr);
    step(0, ren, raddr, 0, 0, 8'd0, 15'd0);
  endtask

  initial begin
    logic [9:0] ra;
    int         k;
    for (int i = 0; i < 512; i++) begin
      ram_mem[i] = 15'($urandom);
      mmem[i]    = ram_mem[i];
    end
    reset = 1; rd_en = 0; rd_addr = '0; wr_req = 0; wr_bank = 0; wr_x = '0; wr_data = '0;
    m_fetched = 0; m_last = '0; m_shown = '0;
    @(posedge clk);
    #1;
    step(1, 0, 10'd0, 0, 0, 8'd0, 15'd0);
    step(1, 0, 10'd0, 0, 0, 8'd0, 15'd0);

    // Doubled read stepping: fetches only at 0 and 2.
    for (int i = 0; i < 4; i++) rd_only(1, 10'(i));
    rd_only(1, 10'd3);
    rd_only(0, 10'd3);

    // Fill the FIFO behind back-to-back reads, then let it drain in order.
    for (int i = 0; i < 6; i++)
      step(0, 1, 10'(100 + 2 * i), 1, 0, 8'($urandom), 15'($urandom));
    for (int i = 0; i < 6; i++) rd_only(0, 10'd0);

    // Full line sweep of bank 0 while the PPU fills bank 1, then read bank 1.
    for (int i = 0; i < 512; i++)
      step(0, 1, 10'(i), (i % 4) == 0, 1, 8'(i / 4), 15'($urandom));
    for (int i = 0; i < 512; i++) rd_only(1, 10'(512 + i));
    rd_only(0, 10'd0);

    // Write to {1,17} near the moment column 17 is fetched.
    for (int rep = 0; rep < 4; rep++) begin
      k = 34 - rep;
      for (int i = 0; i < 48; i++)
        step(0, 1, 10'(512 + i), i == k, 1, 8'd17, 15'h1234 + 15'(rep));
      rd_only(0, 10'd0);
    end

    // Reset with three writes still queued.
    for (int i = 0; i < 3; i++)
      step(0, 1, 10'(200 + 2 * i), 1, 1, 8'(60 + i), 15'($urandom));
    step(1, 1, 10'd204, 0, 0, 8'd0, 15'd0);
    rd_only(1, 10'd204);
    rd_only(1, 10'd205);
    rd_only(0, 10'd205);

    // Blanking at an unchanged address still forces a refetch.
    rd_only(1, 10'h200);
    rd_only(1, 10'h201);
    rd_only(0, 10'h200);
    rd_only(1, 10'h200);
    rd_only(1, 10'h201);

    // Random traffic.
    ra = '0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) ra = 10'($urandom);
      else ra = ra + 10'd1;
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0, ra,
           1'($urandom), 1'($urandom), 8'($urandom), 15'($urandom));
    end
    rd_only(0, 10'd0);
    for (int i = 0; i < 6; i++) rd_only(0, 10'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
